wb_burst_master: RTL

Wishbone B3 burst master sitting directly upstream of the SDRAM controller's Wishbone slave port. It turns simple command and write-data streams into single or incrementing-burst Wishbone cycles (CTI 000/010/111) and returns read data as a stream. A per-beat ack timeout prevents bus lockup. It holds off all commands until SDRAM initialisation completes.

---
 rtl/wb_burst_pkg.sv | 28 ++
 rtl/wbm_ack_timeout.sv | 28 ++
 rtl/wb_burst_master.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_pkg.sv
// Shared types and constants for the Wishbone burst master.
// Holds the state encoding, CTI codes and the per-beat CTI helper.
package wb_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_FINISH
    } wbm_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Single-beat commands use classic cycles; bursts end with EOB.
    function automatic logic [2:0] cti_for(
        input logic [7:0] beat,
        input logic [7:0] len
    );
        if (len == 8'd1)
            return CTI_CLASSIC;
        if (beat == len - 8'd1)
            return CTI_EOB;
        return CTI_INCR;
    endfunction

endpackage

// File: rtl/wbm_ack_timeout.sv
// Per-beat ack watchdog for the burst master.
// expired fires in the cycle the count_en run would reach TIMEOUT.
module wbm_ack_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (count_en)
            cnt <= cnt + CW'(1);
    end

    assign expired = count_en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master feeding the SDRAM controller slave port.
// Turns command/write streams into classic or incrementing bursts.
module wb_burst_master
    import wb_burst_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 26,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255,
    localparam int LEN_W    = $clog2(MAX_BURST + 1),
    localparam int SW       = DW / 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_resetn,
    input  logic             sdr_init_done,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,

    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_data,
    input  logic [SW-1:0]    wr_sel,

    output logic             rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic             rd_last,

    output logic             done,
    output logic             err,

    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [AW-1:0]    wb_addr_o,
    output logic [DW-1:0]    wb_dat_o,
    output logic [SW-1:0]    wb_sel_o,
    output logic [2:0]       wb_cti_o,
    input  logic             wb_ack_i,
    input  logic [DW-1:0]    wb_dat_i
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    wbm_state_t       state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] beats_acked;
    logic [LEN_W-1:0] beats_loaded;
    logic             hold_full;

    logic             busy;
    logic             ack;
    logic             last_ack;
    logic             len_ok;
    logic             accept;
    logic             load_idle;
    logic             load_run;
    logic             load;
    logic             expired;
    logic [AW-1:0]    addr_next;

    assign busy      = (state == ST_WRITE) || (state == ST_READ);
    assign ack       = wb_ack_i && wb_stb_o;
    assign last_ack  = ack && (beats_acked == len - ONE);
    assign len_ok    = (cmd_len != '0) &&
                       (cmd_len <= LEN_W'(MAX_BURST));
    assign accept    = (state == ST_IDLE) && cmd_ready && cmd_valid;
    assign addr_next = wb_addr_o + AW'(SW);

    // The first write beat is taken together with the command so the
    // bus cycle can open on the very next clock.
    assign load_idle = accept && cmd_we && len_ok;
    assign load_run  = (state == ST_WRITE) &&
                       (!hold_full || wb_ack_i) &&
                       (beats_loaded < len);
    assign wr_ready  = load_idle || load_run;
    assign load      = wr_valid && wr_ready;

    wbm_ack_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (wb_clk_i),
        .rst_n    (wb_resetn),
        .clear    (!busy || wb_ack_i),
        .count_en (busy && wb_stb_o && !wb_ack_i),
        .expired  (expired)
    );

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state        <= ST_IDLE;
            len          <= '0;
            beats_acked  <= '0;
            beats_loaded <= '0;
            hold_full    <= 1'b0;
            cmd_ready    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_last      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_addr_o    <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_cti_o     <= CTI_CLASSIC;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    cmd_ready <= sdr_init_done;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        if (!len_ok) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            len          <= cmd_len;
                            wb_we_o      <= cmd_we;
                            wb_addr_o    <= cmd_addr;
                            beats_acked  <= '0;
                            beats_loaded <= '0;
                            if (cmd_we) begin
                                state <= ST_WRITE;
                                if (wr_valid) begin
                                    hold_full    <= 1'b1;
                                    wb_cyc_o     <= 1'b1;
                                    wb_stb_o     <= 1'b1;
                                    wb_dat_o     <= wr_data;
                                    wb_sel_o     <= wr_sel;
                                    wb_cti_o     <= cti_for(8'd0, 8'(cmd_len));
                                    beats_loaded <= ONE;
                                end
                            end else begin
                                state    <= ST_READ;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_cti_o <= cti_for(8'd0, 8'(cmd_len));
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (expired) begin
                        state     <= ST_FINISH;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        hold_full <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        if (ack) begin
                            beats_acked <= beats_acked + ONE;
                            wb_addr_o   <= addr_next;
                        end
                        if (last_ack) begin
                            state     <= ST_FINISH;
                            wb_cyc_o  <= 1'b0;
                            wb_stb_o  <= 1'b0;
                            hold_full <= 1'b0;
                            done      <= 1'b1;
                        end else if (load) begin
                            hold_full    <= 1'b1;
                            wb_cyc_o     <= 1'b1;
                            wb_stb_o     <= 1'b1;
                            wb_dat_o     <= wr_data;
                            wb_sel_o     <= wr_sel;
                            wb_cti_o     <= cti_for(8'(beats_loaded), 8'(len));
                            beats_loaded <= beats_loaded + ONE;
                        end else if (ack) begin
                            // Producer starved: master wait state.
                            hold_full <= 1'b0;
                            wb_stb_o  <= 1'b0;
                        end
                    end
                end

                ST_READ: begin
                    if (expired) begin
                        state    <= ST_FINISH;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                    end else if (ack) begin
                        beats_acked <= beats_acked + ONE;
                        wb_addr_o   <= addr_next;
                        rd_valid    <= 1'b1;
                        rd_data     <= wb_dat_i;
                        if (last_ack) begin
                            rd_last  <= 1'b1;
                            state    <= ST_FINISH;
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            wb_cti_o <= cti_for(8'(beats_acked + ONE), 8'(len));
                        end
                    end
                end

                ST_FINISH: begin
                    state     <= ST_IDLE;
                    cmd_ready <= sdr_init_done;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
